mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Sequencing stage that sits directly upstream of the 4-to-1 gate-level multiplexer and also consumes its single-bit output. It accepts a 4-bit word over a valid/ready handshake and drives that word onto the mux data inputs. It then steps the mux select through 0, 1, 2, 3, holding each value a programmable number of cycles, and captures the mux output bit for each select value. When the scan completes, it presents the reassembled word and a mismatch flag over a second valid/ready handshake.

## Interface
Parameters:
- HOLD_CYCLES, default 1: number of cycles each select value is held. Legal range is 1..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  upstream offers load_data.
- load_ready  out  1  block can accept a word.
- load_data  in  4  word to scan.
- mux_sel  out  2  drives the mux select.
- mux_in  out  4  drives the mux data inputs.
- mux_ans  in  1  mux output, combinational from mux_sel/mux_in.
- out_valid  out  1  out_data/out_err are valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  4  captured word; bit k is mux_ans sampled while mux_sel == k.
- out_err  out  1  1 when out_data != latched load word.

## Operation
- FSM states are IDLE, SCAN and DONE. Reset enters IDLE.
- IDLE:
  - load_ready = 1 and mux_sel = 0.
  - A load happens on a cycle with load_valid && load_ready. At that edge the block latches load_data into mux_in, clears the capture register and hold counter, sets mux_sel = 0, and enters SCAN.
- SCAN:
  - The hold counter counts 0..HOLD_CYCLES-1 with mux_sel constant.
  - On the cycle where the counter equals HOLD_CYCLES-1, the block writes mux_ans into capture[mux_sel] at the edge.
  - If mux_sel == 3, the block enters DONE. Otherwise mux_sel increments and the counter clears.
  - load_valid is ignored in SCAN.
- DONE:
  - out_valid = 1. out_data = capture register. out_err = (capture != mux_in).
  - mux_sel returns to 0, and mux_in holds the last word.
  - On out_ready at the edge, the block enters IDLE.
- The only path out of DONE is out_ready, so no new load is accepted until the result is consumed. load_ready and out_valid are never high together.
- mux_in holds the latched word from load through DONE and keeps it after return to IDLE, until the next load.

## Timing
- Reset values:
  - state IDLE, so load_ready = 1.
  - mux_sel = 0, mux_in = 0, out_valid = 0, out_data = 0, out_err = 0.
  - hold counter 0, capture 0.
- Outputs:
  - load_ready and out_valid are decoded from state (Moore).
  - mux_sel, mux_in and the capture register are registered.
  - out_err is a registered compare result or a decode of registers, with no combinational path from any input.
- Latency:
  - A load accepted at edge t gives SCAN for 4*HOLD_CYCLES cycles.
  - out_valid is first high in the cycle after edge t + 4*HOLD_CYCLES.
  - With HOLD_CYCLES = 1, out_valid is high 5 cycles after the load edge.
- mux_ans is sampled the same cycle mux_sel/mux_in are stable. This is legal because the mux is combinational and mux_sel has been stable for at least one full cycle.
- Throughput: one word per 4*HOLD_CYCLES + 2 cycles when out_ready is held high and load_valid is continuous.
- out_valid with out_ready low: out_valid, out_data and out_err remain stable indefinitely.
- Reset mid-SCAN or in DONE: the block aborts immediately to reset values. A partial capture is never presented.
- The counter is 4 bits wide. HOLD_CYCLES outside 1..15 is a compile-time error (elaboration assertion).

## Structure
- Package mux_scan_pkg contains:
  - typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t.
  - localparam SEL_LAST = 2'd3.
  - localparam HOLD_W = 4.
- One natural sub-module, mux_scan_hold_cnt. It holds the counter with clear/enable inputs and a terminal-count output (count == HOLD_CYCLES-1).
- The top holds the FSM, select register, data latch and capture register.
- Benches instantiate the real 4-to-1 gate-level mux downstream, with its sel/in tied to mux_sel/mux_in and its ans driving mux_ans.

## Test plan
- Reset/idle: with HOLD_CYCLES = 1, release rst_n → load_ready = 1, out_valid = 0, mux_sel = 0, mux_in = 4'h0.
- Basic scan: HOLD_CYCLES = 1, load 4'hA with out_ready = 1.
  - mux_sel sequences 0,1,2,3 on consecutive cycles.
  - out_valid rises 5 cycles after the load edge with out_data = 4'hA, out_err = 0.
- Hold count: HOLD_CYCLES = 3, load 4'h5 → each mux_sel value persists exactly 3 cycles, and out_valid rises 13 cycles after load with out_data = 4'h5.
- Fault detect: HOLD_CYCLES = 1, load 4'hF, force mux_ans = 0 while mux_sel == 2 → out_data = 4'hB, out_err = 1.
- Backpressure: complete a scan of 4'h3 with out_ready = 0 for 10 cycles.
  - out_valid, out_data = 4'h3 and out_err stay stable, and load_ready stays 0 with load_valid = 1 held.
  - Raising out_ready returns the block to IDLE the next cycle.
- Reset mid-scan: load 4'hC, assert rst_n low while mux_sel == 2 → all outputs at reset values asynchronously; after release, a new load of 4'h6 scans and returns out_data = 4'h6.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan controller.
//   scan_state_t : controller FSM encoding (IDLE, SCAN, DONE)
//   SEL_LAST     : last mux select value in a scan
//   HOLD_W       : width of the per-select hold counter
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  localparam logic [1:0] SEL_LAST = 2'd3;
  localparam int         HOLD_W   = 4;

endpackage

// File: rtl/mux_scan_hold_cnt.sv
// Hold counter: counts 0..HOLD_CYCLES-1 while enabled, then wraps to 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear (wins over enable)
//   i_en       : count enable
//   o_tc       : terminal count, high while count == HOLD_CYCLES-1
module mux_scan_hold_cnt
  import mux_scan_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [HOLD_W-1:0] TC_VAL = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] r_count;

  assign o_tc = (r_count == TC_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      // Wrap at terminal count so the next select value starts from 0.
      r_count <= o_tc ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4-to-1 combinational mux. Accepts a 4-bit word,
// drives it onto the mux data inputs, steps the select through 0..3 holding
// each value HOLD_CYCLES cycles, captures the mux output per select, and
// presents the reassembled word plus a mismatch flag.
//
// Handshakes: a transfer occurs on a rising edge where valid && ready are
// both high. load_ready is high only in IDLE, out_valid only in DONE, so the
// two are never high together; out_* stay stable while out_ready is low.
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   load_valid/ready/data  : input word handshake
//   mux_sel, mux_in        : registered drive to the mux
//   mux_ans                : mux output (combinational from mux_sel/mux_in)
//   out_valid/ready        : result handshake
//   out_data, out_err      : captured word, mismatch against loaded word
//   o_dbg_state            : current FSM state for observation
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [3:0]  load_data,
  output logic [1:0]  mux_sel,
  output logic [3:0]  mux_in,
  input  logic        mux_ans,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_data,
  output logic        out_err,
  output scan_state_t o_dbg_state
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("mux_scan_ctrl: HOLD_CYCLES must be in 1..15");
  end

  scan_state_t r_state;
  scan_state_t w_next_state;
  logic [1:0]  r_sel;
  logic [3:0]  r_mux_in;
  logic [3:0]  r_capture;
  logic        w_load;
  logic        w_tc;
  logic        w_step;

  assign w_load = load_valid && (r_state == IDLE);
  // A capture happens on the last hold cycle of each select value.
  assign w_step = (r_state == SCAN) && w_tc;

  mux_scan_hold_cnt #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_load),
    .i_en  (r_state == SCAN),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    load_ready   = 1'b0;
    out_valid    = 1'b0;
    out_data     = 4'h0;
    out_err      = 1'b0;
    case (r_state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) w_next_state = SCAN;
      end
      SCAN: begin
        if (w_tc && (r_sel == SEL_LAST)) w_next_state = DONE;
      end
      DONE: begin
        // Result is gated by state so a partial capture is never visible.
        out_valid = 1'b1;
        out_data  = r_capture;
        out_err   = (r_capture != r_mux_in);
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel     <= 2'd0;
      r_mux_in  <= 4'h0;
      r_capture <= 4'h0;
    end else if (w_load) begin
      r_sel     <= 2'd0;
      r_mux_in  <= load_data;
      r_capture <= 4'h0;
    end else if (w_step) begin
      r_capture[r_sel] <= mux_ans;
      // After the last select the mux is parked back at 0 for DONE/IDLE.
      r_sel <= (r_sel == SEL_LAST) ? 2'd0 : r_sel + 2'd1;
    end
  end

  assign mux_sel     = r_sel;
  assign mux_in      = r_mux_in;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: one instance with HOLD_CYCLES=1 (with a stuck-at-0
// fault-injectable mux model) and one with HOLD_CYCLES=3.
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (HOLD_CYCLES = 1) ----------------
  logic        load_valid1, load_ready1, mux_ans1, out_valid1, out_ready1, out_err1;
  logic [3:0]  load_data1, mux_in1, out_data1;
  logic [1:0]  mux_sel1;
  scan_state_t dbg_state1;

  // ---------------- DUT (HOLD_CYCLES = 3) ----------------
  logic        load_valid3, load_ready3, mux_ans3, out_valid3, out_ready3, out_err3;
  logic [3:0]  load_data3, mux_in3, out_data3;
  logic [1:0]  mux_sel3;
  scan_state_t dbg_state3;

  // 4-to-1 mux model; fault_en forces the output low while fault_sel is selected.
  logic       fault_en = 1'b0;
  logic [1:0] fault_sel = 2'd0;
  assign mux_ans1 = (fault_en && (mux_sel1 == fault_sel)) ? 1'b0 : mux_in1[mux_sel1];
  assign mux_ans3 = mux_in3[mux_sel3];

  mux_scan_ctrl #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid1), .load_ready(load_ready1), .load_data(load_data1),
    .mux_sel(mux_sel1), .mux_in(mux_in1), .mux_ans(mux_ans1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_err(out_err1), .o_dbg_state(dbg_state1)
  );

  mux_scan_ctrl #(.HOLD_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid3), .load_ready(load_ready3), .load_data(load_data3),
    .mux_sel(mux_sel3), .mux_in(mux_in3), .mux_ans(mux_ans3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_err(out_err3), .o_dbg_state(dbg_state3)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];   // {err, data} expected from u_dut1, in order

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare each result accepted from u_dut1 against the queue.
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst_n && out_valid1 && out_ready1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got data %0h with no expected entry", out_data1);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", {4'h0, out_data1}, {4'h0, e[3:0]});
        check("sb_err",  {7'h0, out_err1},  {7'h0, e[4]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns just after the accepting edge.
  task automatic do_load1(input logic [3:0] d);
    int k;
    k = 0;
    @(negedge clk);
    while (load_ready1 !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (load_ready1 !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout_load_ready: got 0 expected 1");
    end
    load_valid1 = 1'b1;
    load_data1  = d;
    @(posedge clk);
    #1;
    load_valid1 = 1'b0;
  endtask

  // Returns at the negedge where out_valid1 is first seen high.
  task automatic wait_out1(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (out_valid1 !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (out_valid1 !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout_out_valid: got 0 expected 1");
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_load_ready"}, {7'h0, load_ready1}, 8'h1);
    check({tag, "_out_valid"},  {7'h0, out_valid1},  8'h0);
    check({tag, "_mux_sel"},    {6'h0, mux_sel1},    8'h0);
    check({tag, "_mux_in"},     {4'h0, mux_in1},     8'h0);
    check({tag, "_out_data"},   {4'h0, out_data1},   8'h0);
    check({tag, "_out_err"},    {7'h0, out_err1},    8'h0);
    check({tag, "_state"},      {6'h0, dbg_state1},  {6'h0, IDLE});
  endtask

  typedef struct {
    logic [3:0] data;
    logic       f_en;
    logic [1:0] f_sel;
    logic [3:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[7];

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] d, m;
    logic [1:0] fs;
    logic       fe;
    int         k;

    vecs[0] = '{data: 4'hA, f_en: 1'b0, f_sel: 2'd0, exp_data: 4'hA, exp_err: 1'b0};
    vecs[1] = '{data: 4'hF, f_en: 1'b1, f_sel: 2'd2, exp_data: 4'hB, exp_err: 1'b1};
    vecs[2] = '{data: 4'h0, f_en: 1'b0, f_sel: 2'd0, exp_data: 4'h0, exp_err: 1'b0};
    vecs[3] = '{data: 4'hF, f_en: 1'b1, f_sel: 2'd0, exp_data: 4'hE, exp_err: 1'b1};
    vecs[4] = '{data: 4'h9, f_en: 1'b1, f_sel: 2'd3, exp_data: 4'h1, exp_err: 1'b1};
    vecs[5] = '{data: 4'h6, f_en: 1'b1, f_sel: 2'd1, exp_data: 4'h4, exp_err: 1'b1};
    vecs[6] = '{data: 4'h1, f_en: 1'b1, f_sel: 2'd1, exp_data: 4'h1, exp_err: 1'b0};

    load_valid1 = 1'b0; load_data1 = 4'h0; out_ready1 = 1'b0;
    load_valid3 = 1'b0; load_data3 = 4'h0; out_ready3 = 1'b0;

    // Reset / idle
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("idle");

    // Basic scan, HOLD_CYCLES=1: one select per cycle, DONE after 4 edges.
    out_ready1 = 1'b1;
    do_load1(4'hA);
    exp_q.push_back({1'b0, 4'hA});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("basic_sel", {6'h0, mux_sel1}, 8'(i));
      check("basic_valid_low", {7'h0, out_valid1}, 8'h0);
      check("basic_ready_low", {7'h0, load_ready1}, 8'h0);
    end
    @(negedge clk);
    check("basic_valid_high", {7'h0, out_valid1}, 8'h1);
    check("basic_mux_in", {4'h0, mux_in1}, 8'hA);
    check("basic_sel_parked", {6'h0, mux_sel1}, 8'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("basic_back_idle", {7'h0, load_ready1}, 8'h1);
    check("basic_mux_in_kept", {4'h0, mux_in1}, 8'hA);

    // Hold count, HOLD_CYCLES=3: each select held 3 cycles, DONE after 12 edges.
    out_ready3 = 1'b1;
    @(negedge clk);
    load_valid3 = 1'b1;
    load_data3  = 4'h5;
    @(posedge clk); #1;
    load_valid3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        check("hold_sel", {6'h0, mux_sel3}, 8'(i));
        check("hold_valid_low", {7'h0, out_valid3}, 8'h0);
      end
    end
    @(negedge clk);
    check("hold_valid_high", {7'h0, out_valid3}, 8'h1);
    check("hold_data", {4'h0, out_data3}, 8'h5);
    check("hold_err", {7'h0, out_err3}, 8'h0);
    @(posedge clk); #1;

    // Table-driven vectors, including stuck-at-0 faults on each select.
    for (int i = 0; i < 7; i++) begin
      fault_en  = vecs[i].f_en;
      fault_sel = vecs[i].f_sel;
      do_load1(vecs[i].data);
      exp_q.push_back({vecs[i].exp_err, vecs[i].exp_data});
      wait_out1(20);
      @(posedge clk); #1;
    end

    // Random words with an optional random stuck-at-0 select.
    for (int i = 0; i < 6; i++) begin
      d  = 4'($urandom_range(0, 15));
      fs = 2'($urandom_range(0, 3));
      fe = 1'($urandom_range(0, 1));
      m  = d;
      if (fe) m[fs] = 1'b0;
      fault_en  = fe;
      fault_sel = fs;
      do_load1(d);
      exp_q.push_back({(m != d), m});
      wait_out1(20);
      @(posedge clk); #1;
    end
    fault_en = 1'b0;

    // Backpressure: result holds, no load accepted while DONE.
    out_ready1 = 1'b0;
    do_load1(4'h3);
    exp_q.push_back({1'b0, 4'h3});
    wait_out1(20);
    load_valid1 = 1'b1;
    load_data1  = 4'h7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", {7'h0, out_valid1}, 8'h1);
      check("bp_data", {4'h0, out_data1}, 8'h3);
      check("bp_err", {7'h0, out_err1}, 8'h0);
      check("bp_load_ready", {7'h0, load_ready1}, 8'h0);
    end
    @(posedge clk); #1;
    load_valid1 = 1'b0;
    out_ready1  = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_idle", {7'h0, load_ready1}, 8'h1);
    check("bp_release_valid", {7'h0, out_valid1}, 8'h0);

    // Reset mid-scan: abort asynchronously, then a fresh scan works.
    do_load1(4'hC);
    k = 0;
    @(negedge clk);
    while (mux_sel1 !== 2'd2 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("midrst_reached_sel2", {6'h0, mux_sel1}, 8'h2);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    do_load1(4'h6);
    exp_q.push_back({1'b0, 4'h6});
    wait_out1(20);
    @(posedge clk); #1;
    @(negedge clk);

    check("sb_drained", 8'(exp_q.size()), 8'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
